mips_fetch_queue: RTL and testbench
===================================

Name: mips_fetch_queue

Overview:
Instruction-fetch front end feeding the decode stage of the pipelined MIPS core; replaces the direct imem read in the fetch stage.
- Issues word addresses to a variable-latency instruction memory over a valid/ready request channel.
- Buffers returned instructions in a small FIFO and presents one instruction per cycle to decode as cmdD/PCPlusFourD.
- Honours the StallD and PCSrcD/PCBranchD redirect signals from the hazard unit and decode.

Parameters:
DEPTH, 4, instruction FIFO entries; power of two, 2..16
MAX_OUT, 2, maximum in-flight imem requests, 1..DEPTH
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; one clock; asynchronous, active-low
StallD  in  1  decode stall: hold cmdD/PCPlusFourD/validD
PCSrcD  in  1  branch taken in decode: redirect fetch
PCBranchD  in  32  redirect target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order; always accepted, no backpressure
imem_rsp_data  in  32  instruction word
cmdD  out  32  instruction to decode; 0 (sll $0 NOP) when invalid
PCPlusFourD  out  32  address of cmdD + 4
validD  out  1  cmdD holds a real instruction

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - fetch PC = RESET_PC.
  - FIFO count, outstanding count O, and drop count X are 0.
  - validD=0, cmdD=0, PCPlusFourD=0, imem_req_valid=0.
- Request issue: imem_req_valid = !redir && O < MAX_OUT && (fifo_count + O − X) < DEPTH.
  - redir = PCSrcD && !StallD.
  - imem_req_addr = fetch PC, driven combinationally.
  - Handshake completes when valid && ready: PC += 4 (wraps mod 2^32), O += 1.
  - If ready=0, valid and addr stay stable while the issue condition holds.
- Address tag FIFO (depth MAX_OUT) records each accepted address; it pops on each response.
- Response handling:
  - On imem_rsp_valid: O −= 1 and the tag pops.
  - If X > 0: X −= 1 and the data is discarded.
  - Otherwise {data, tag+4} enters the instruction path.
  - A response in the same cycle as a request leaves O unchanged.
- Decode register:
  - Loads on every edge with StallD=0.
  - Source: FIFO head if non-empty; else the current accepted response (bypass, zero-cycle FIFO latency); else a bubble (validD=0, cmdD=0, PCPlusFourD unchanged).
  - StallD=1: the decode register holds; accepted responses enter the FIFO.
- Latency: an instruction returned at cycle t with an empty FIFO and StallD=0 appears on cmdD at cycle t+1.
- Redirect, when PCSrcD=1 and StallD=0:
  - fetch PC ← PCBranchD.
  - FIFO flushed.
  - Decode register loads a bubble.
  - No request issued this cycle.
  - X ← O − imem_rsp_valid; a response arriving in the redirect cycle is also discarded.
  - Fetch restarts next cycle.
- PCSrcD while StallD=1 is ignored; the branch is not yet resolved.
- Full FIFO: no issue; in-flight responses always have room by the credit rule. Overflow is a design error.
- O never exceeds MAX_OUT; X ≤ O at all times.
- Reset asserted mid-transfer: all state clears immediately.
  - The memory is reset by the same rst_n, so no stale responses arrive after release.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_bubbles[31:0] and perf_redirects[31:0].
  - Both are 0 on reset.
  - perf_bubbles increments each StallD=0 edge that loads a bubble.
  - perf_redirects increments each accepted redirect.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release, ready=1, 1-cycle memory returning addr|0xA000 -> requests 0x0,0x4,0x8…; cmdD = 0xA000,0xA004,… back-to-back, PCPlusFourD = 0x4,0x8,…; validD=1 from cycle 3.
2. StallD=1 for 6 cycles with DEPTH=4 -> at most 4 FIFO entries plus in-flight, imem_req_valid drops; on release the instruction order is contiguous with no loss or duplication.
3. 3-cycle latency memory, MAX_OUT=2, PCSrcD pulse with PCBranchD=0x100 while O=2 -> next cmdD after bubble is mem[0x100], PCPlusFourD=0x104; both stale responses discarded.
4. PCSrcD=1 with StallD=1 -> no redirect and no flush; sequential fetch continues.
5. imem_req_ready=0 for 5 cycles -> imem_req_addr held constant; decode sees bubbles with cmdD=0 and validD=0.
6. rst_n pulsed low mid-stream -> all outputs zero immediately; fetch restarts at RESET_PC. With FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/mips_fetch_queue_if.sv
// mips_fetch_queue_if: instruction-memory request/response channel.
// The fetch queue is the master; the instruction memory is the slave.
interface mips_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: fetch front end issuing imem requests and buffering instructions for decode.
// Defining FETCH_PERF_EN adds saturating bubble/redirect performance counters.
module mips_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               StallD,
    input  logic               PCSrcD,
    input  logic [31:0]        PCBranchD,
    mips_fetch_queue_if.master imem,
    output logic [31:0]        cmdD,
    output logic [31:0]        PCPlusFourD,
    output logic               validD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_redirects
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   pc_q, pc_d, cmd_q, cmd_d, pc4_q, pc4_d, rsp_pc4;
    logic [OW-1:0] out_q, out_d, drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic          valid_q, valid_d;
    logic          redir, req_fire, rsp_keep, fifo_pop, fifo_push, load_bub;
    logic [31:0]   fifo_cmd [DEPTH];
    logic [31:0]   fifo_pc4 [DEPTH];
    logic [31:0]   tag_mem  [MAX_OUT];

    // Credit rule: buffered plus live in-flight responses never exceed DEPTH, so responses always fit.
    assign imem.imem_req_valid = rst_n && !redir && 32'(out_q) < MAX_OUT &&
                                 32'(cnt_q) + 32'(out_q) - 32'(drop_q) < DEPTH;
    assign imem.imem_req_addr  = pc_q;
    assign cmdD        = cmd_q;
    assign PCPlusFourD = pc4_q;
    assign validD      = valid_q;

    always_comb begin
        redir     = PCSrcD && !StallD;
        req_fire  = imem.imem_req_valid && imem.imem_req_ready;
        rsp_keep  = imem.imem_rsp_valid && drop_q == '0 && !redir;
        rsp_pc4   = tag_mem[tag_rd_q] + 32'd4;
        fifo_pop  = !StallD && !redir && cnt_q != '0;
        fifo_push = rsp_keep && (StallD || cnt_q != '0);
        load_bub  = !StallD && (redir || (cnt_q == '0 && !rsp_keep));
        pc_d      = redir ? PCBranchD : req_fire ? pc_q + 32'd4 : pc_q;
        out_d     = out_q + OW'(req_fire) - OW'(imem.imem_rsp_valid);
        drop_d    = redir ? out_q - OW'(imem.imem_rsp_valid)
                          : drop_q - OW'(imem.imem_rsp_valid && drop_q != '0);
        cnt_d     = redir ? '0 : cnt_q + CW'(fifo_push) - CW'(fifo_pop);
        rd_d      = redir ? '0 : rd_q + AW'(fifo_pop);
        wr_d      = redir ? '0 : wr_q + AW'(fifo_push);
        tag_wr_d  = !req_fire ? tag_wr_q : tag_wr_q == TW'(MAX_OUT - 1) ? '0 : tag_wr_q + 1'b1;
        tag_rd_d  = !imem.imem_rsp_valid ? tag_rd_q : tag_rd_q == TW'(MAX_OUT - 1) ? '0 : tag_rd_q + 1'b1;
        cmd_d     = StallD ? cmd_q : fifo_pop ? fifo_cmd[rd_q] : rsp_keep ? imem.imem_rsp_data : '0;
        pc4_d     = StallD ? pc4_q : fifo_pop ? fifo_pc4[rd_q] : rsp_keep ? rsp_pc4 : pc4_q;
        valid_d   = StallD ? valid_q : fifo_pop || rsp_keep;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
            cmd_q    <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
            cmd_q    <= cmd_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_cmd[wr_q] <= imem.imem_rsp_data;
            fifo_pc4[wr_q] <= rsp_pc4;
        end
        if (req_fire)
            tag_mem[tag_wr_q] <= pc_q;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bub_q, bub_d, red_q, red_d;

    always_comb begin
        bub_d = load_bub && bub_q != '1 ? bub_q + 32'd1 : bub_q;
        red_d = redir && red_q != '1 ? red_q + 32'd1 : red_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q <= '0;
            red_q <= '0;
        end else begin
            bub_q <= bub_d;
            red_q <= red_d;
        end
    end

    assign perf_bubbles   = bub_q;
    assign perf_redirects = red_q;
`endif
endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb_mips_fetch_queue: directed and random stimulus against an instruction-stream reference model
// with a latency-programmable in-order instruction memory.
module tb_mips_fetch_queue;
    localparam int DEPTH = 4;
    localparam int MAX_OUT = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] a; int due; } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        StallD = 1'b0;
    logic        PCSrcD = 1'b0;
    logic [31:0] PCBranchD = '0;
    logic [31:0] cmdD, PCPlusFourD;
    logic        validD;
    int          total = 0;
    int          bad = 0;

    mips_fetch_queue_if imem();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubbles, perf_redirects;
    int n_bub = 0;
    int n_red = 0;
`endif

    mips_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .StallD(StallD),
        .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD),
        .imem(imem),
        .cmdD(cmdD),
        .PCPlusFourD(PCPlusFourD),
        .validD(validD)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubbles(perf_bubbles),
        .perf_redirects(perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    req_t        pend[$];
    int          cyc = 0, last_due = -1, lat_lo = 1, lat_hi = 1;
    logic [31:0] exp_req, exp_dec, hold_a;
    logic        hold_v = 1'b0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'h0000_A000;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_validD", 32'(validD), 0);
        chk("rst_cmdD", cmdD, 0);
        chk("rst_pc4", PCPlusFourD, 0);
        chk("rst_req_valid", 32'(imem.imem_req_valid), 0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_bubbles", perf_bubbles, 0);
        chk("rst_perf_redirects", perf_redirects, 0);
        n_bub = 0;
        n_red = 0;
`endif
        pend.delete();
        last_due = -1;
        hold_v = 1'b0;
        exp_req = RESET_PC;
        exp_dec = RESET_PC;
        StallD = 1'b0;
        PCSrcD = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: sample pre-edge, let the edge happen, check decode, then drive the memory response.
    task automatic cycle();
        logic s_rv, s_rdy, s_stall, s_redir, p_valid, fire;
        logic [31:0] s_addr, s_br, p_cmd, p_pc4;
        int due;
        @(negedge clk);
        s_rv = imem.imem_req_valid;
        s_rdy = imem.imem_req_ready;
        s_addr = imem.imem_req_addr;
        s_stall = StallD;
        s_redir = PCSrcD && !StallD;
        s_br = PCBranchD;
        p_valid = validD;
        p_cmd = cmdD;
        p_pc4 = PCPlusFourD;
        if (s_redir) chk("no_req_on_redirect", 32'(s_rv), 0);
        if (hold_v && !s_redir) begin
            chk("req_hold_valid", 32'(s_rv), 1);
            chk("req_hold_addr", s_addr, hold_a);
        end
        hold_v = s_rv && !s_rdy;
        hold_a = s_addr;
        fire = s_rv && s_rdy;
        if (fire) chk("req_addr", s_addr, exp_req);
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            exp_req += 32'd4;
            due = cyc + $urandom_range(lat_hi, lat_lo) - 1;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{s_addr, due});
            chk("outstanding_le_max", 32'(pend.size() <= MAX_OUT), 1);
        end
        if (s_redir) exp_req = s_br;
        if (s_stall) begin
            chk("stall_hold_valid", 32'(validD), 32'(p_valid));
            chk("stall_hold_cmd", cmdD, p_cmd);
            chk("stall_hold_pc4", PCPlusFourD, p_pc4);
        end else if (s_redir) begin
            chk("redir_bubble_valid", 32'(validD), 0);
            chk("redir_bubble_cmd", cmdD, 0);
            chk("redir_bubble_pc4", PCPlusFourD, p_pc4);
            exp_dec = s_br;
        end else if (validD) begin
            chk("stream_cmd", cmdD, mem_word(exp_dec));
            chk("stream_pc4", PCPlusFourD, exp_dec + 32'd4);
            exp_dec += 32'd4;
        end else begin
            chk("bubble_cmd", cmdD, 0);
            chk("bubble_pc4", PCPlusFourD, p_pc4);
        end
`ifdef FETCH_PERF_EN
        if (!s_stall && !validD) n_bub++;
        if (s_redir) n_red++;
        chk("perf_bubbles", perf_bubbles, 32'(n_bub));
        chk("perf_redirects", perf_redirects, 32'(n_red));
`endif
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data = mem_word(pend[0].a);
            void'(pend.pop_front());
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data = $urandom;
        end
    endtask

    initial begin
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data = '0;
        #3;
        do_reset();

        // 1: one-cycle memory streams back-to-back
        repeat (2) cycle();
        chk("t1_first_valid", 32'(validD), 1);
        chk("t1_first_cmd", cmdD, 32'h0000_A000);
        chk("t1_first_pc4", PCPlusFourD, 32'h4);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t1_back_to_back", 32'(validD), 1);
        end

        // 2: long stall fills the FIFO and throttles requests
        StallD = 1'b1;
        repeat (6) cycle();
        chk("t2_req_throttled", 32'(imem.imem_req_valid), 0);
        StallD = 1'b0;
        repeat (12) cycle();
        chk("t2_flowing", 32'(validD), 1);

        // 3: redirect with two requests in flight on a three-cycle memory
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 20 && pend.size() + 32'(imem.imem_rsp_valid) != MAX_OUT; i++) cycle();
        chk("t3_two_in_flight", pend.size() + 32'(imem.imem_rsp_valid), MAX_OUT);
        PCSrcD = 1'b1;
        PCBranchD = 32'h100;
        cycle();
        PCSrcD = 1'b0;
        for (int i = 0; i < 20 && !validD; i++) cycle();
        chk("t3_target_cmd", cmdD, mem_word(32'h100));
        chk("t3_target_pc4", PCPlusFourD, 32'h104);

        // 4: branch signal during stall is ignored
        lat_lo = 1;
        lat_hi = 1;
        StallD = 1'b1;
        PCSrcD = 1'b1;
        PCBranchD = 32'h800;
        repeat (2) cycle();
        StallD = 1'b0;
        PCSrcD = 1'b0;
        repeat (8) cycle();
        chk("t4_no_redirect", 32'(PCPlusFourD < 32'h800), 1);

        // 5: memory not ready: address held, decode drains to bubbles
        imem.imem_req_ready = 1'b0;
        repeat (5) cycle();
        chk("t5_bubble_valid", 32'(validD), 0);
        chk("t5_bubble_cmd", cmdD, 0);
        imem.imem_req_ready = 1'b1;
        repeat (4) cycle();

        // 6: reset mid-stream
        do_reset();
        repeat (2) cycle();
        chk("t6_restart_cmd", cmdD, mem_word(RESET_PC));
        repeat (4) cycle();

        // randomized traffic
        lat_hi = 4;
        for (int i = 0; i < 600; i++) begin
            StallD = ($urandom % 10) < 3;
            PCSrcD = ($urandom % 20) == 0;
            PCBranchD = 32'($urandom_range(1023, 0)) << 2;
            imem.imem_req_ready = ($urandom % 10) < 7;
            cycle();
        end
        StallD = 1'b0;
        PCSrcD = 1'b0;
        imem.imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !validD; i++) cycle();
        chk("final_liveness", 32'(validD), 1);
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
